uart_rx_deframer: RTL

- Receive half of the UART: oversamples the asynchronous serial line `Rx`, locates start bits and samples each bit at mid-bit.
- Checks parity, stop and break conditions, then presents one deframed word plus a 3-bit error code to the receive FIFO.
- Drives `RTS` flow control from FIFO occupancy.
- Sits between the `Rx` pin and the RX FIFO, in parallel with the transmitter, and is also the loopback target during BIST.

---
 rtl/uart_rx_deframer_if.sv | 23 ++
 rtl/uart_rx_deframer.sv | 160 ++++++++++++++++
 2 files changed

// File: rtl/uart_rx_deframer_if.sv
// Receive-side pin, FIFO push and flow-control bundle for the UART deframer.
// The master side is the deframer, and the slave side is the FIFO/pin environment.
interface uart_rx_deframer_if #(
    parameter int DATA_BITS = 8
);
    logic                 Rx;
    logic                 FIFO_Full;
    logic                 RTS;
    logic [DATA_BITS-1:0] Rx_Data;
    logic                 Data_Rdy;
    logic [2:0]           Rx_Error;
    logic                 Rx_Busy;

    modport master (
        input  Rx, FIFO_Full,
        output RTS, Rx_Data, Data_Rdy, Rx_Error, Rx_Busy
    );

    modport slave (
        output Rx, FIFO_Full,
        input  RTS, Rx_Data, Data_Rdy, Rx_Error, Rx_Busy
    );
endinterface

// File: rtl/uart_rx_deframer.sv
// UART receive deframer: it samples each bit at mid-bit and pushes {data, error} one cycle after the last stop sample.
// It has no backpressure: pushes happen even when FIFO_Full is set, and RTS only reflects FIFO occupancy.
module uart_rx_deframer #(
    parameter int SYSCLK_RATE = 100000000,
    parameter int BAUD_RATE   = 9600,
    parameter int DATA_BITS   = 8,
    parameter int PARITY_BIT  = 1,
    parameter int STOP_BITS   = 2
) (
    input  logic               Clk,
    input  logic               Rst,
    uart_rx_deframer_if.master bus
);
    localparam int CLKS_PER_BIT = SYSCLK_RATE / BAUD_RATE;
    localparam int HALF         = CLKS_PER_BIT / 2;
    localparam int CCNT_W       = $clog2(CLKS_PER_BIT);
    localparam int BCNT_W       = 4;

    generate
        if (CLKS_PER_BIT < 4) begin : g_bad_rate
            $error("uart_rx_deframer: CLKS_PER_BIT must be >= 4");
        end
    endgenerate

    typedef enum logic [2:0] {
        S_IDLE, S_START, S_DATA, S_PARITY, S_STOP, S_DONE, S_BRK_WAIT
    } state_t;

    state_t               state, state_n;
    logic                 rx_meta, rxs;
    logic                 rts_q;
    logic [CCNT_W-1:0]    ccnt, ccnt_n;
    logic [BCNT_W-1:0]    bcnt, bcnt_n;
    logic [DATA_BITS-1:0] shreg, shreg_n;
    logic                 perr, perr_n, ferr, ferr_n, brk, brk_n;
    logic [DATA_BITS-1:0] rx_data_q, rx_data_n;
    logic [2:0]           rx_err_q, rx_err_n;
    logic                 rdy_q, rdy_n;
    logic                 bit_end;

    assign bit_end = (ccnt == CCNT_W'(CLKS_PER_BIT - 1));

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            rx_meta   <= 1'b1;
            rxs       <= 1'b1;
            rts_q     <= 1'b0;
            state     <= S_IDLE;
            ccnt      <= '0;
            bcnt      <= '0;
            shreg     <= '0;
            perr      <= 1'b0;
            ferr      <= 1'b0;
            brk       <= 1'b0;
            rx_data_q <= '0;
            rx_err_q  <= '0;
            rdy_q     <= 1'b0;
        end else begin
            rx_meta   <= bus.Rx;
            rxs       <= rx_meta;
            rts_q     <= !bus.FIFO_Full;
            state     <= state_n;
            ccnt      <= ccnt_n;
            bcnt      <= bcnt_n;
            shreg     <= shreg_n;
            perr      <= perr_n;
            ferr      <= ferr_n;
            brk       <= brk_n;
            rx_data_q <= rx_data_n;
            rx_err_q  <= rx_err_n;
            rdy_q     <= rdy_n;
        end
    end

    always_comb begin
        state_n   = state;
        ccnt_n    = ccnt;
        bcnt_n    = bcnt;
        shreg_n   = shreg;
        perr_n    = perr;
        ferr_n    = ferr;
        brk_n     = brk;
        rx_data_n = rx_data_q;
        rx_err_n  = rx_err_q;
        rdy_n     = 1'b0;
        unique case (state)
            S_IDLE: begin
                ccnt_n = '0;
                bcnt_n = '0;
                if (!rxs) begin
                    state_n = S_START;
                    perr_n  = 1'b0;
                    ferr_n  = 1'b0;
                    brk_n   = 1'b1;
                end
            end
            S_START: begin
                if (ccnt == CCNT_W'(HALF - 1)) begin
                    ccnt_n  = '0;
                    state_n = rxs ? S_IDLE : S_DATA;
                end else begin
                    ccnt_n = ccnt + CCNT_W'(1);
                end
            end
            S_DATA: begin
                if (bit_end) begin
                    ccnt_n  = '0;
                    shreg_n = DATA_BITS'({shreg, rxs});
                    if (rxs) brk_n = 1'b0;
                    if (bcnt == BCNT_W'(DATA_BITS - 1)) begin
                        bcnt_n  = '0;
                        state_n = (PARITY_BIT != 0) ? S_PARITY : S_STOP;
                    end else begin
                        bcnt_n = bcnt + BCNT_W'(1);
                    end
                end else begin
                    ccnt_n = ccnt + CCNT_W'(1);
                end
            end
            S_PARITY: begin
                if (bit_end) begin
                    ccnt_n  = '0;
                    perr_n  = rxs ^ (^shreg);
                    if (rxs) brk_n = 1'b0;
                    state_n = S_STOP;
                end else begin
                    ccnt_n = ccnt + CCNT_W'(1);
                end
            end
            S_STOP: begin
                if (bit_end) begin
                    ccnt_n = '0;
                    if (!rxs) ferr_n = 1'b1;
                    else      brk_n  = 1'b0;
                    // Result is registered on the last stop sample so it is valid during the DONE cycle.
                    if (bcnt == BCNT_W'(STOP_BITS - 1)) begin
                        bcnt_n    = '0;
                        state_n   = S_DONE;
                        rdy_n     = 1'b1;
                        rx_data_n = shreg;
                        rx_err_n  = brk_n ? 3'b001 : {ferr_n, perr_n, 1'b0};
                    end else begin
                        bcnt_n = bcnt + BCNT_W'(1);
                    end
                end else begin
                    ccnt_n = ccnt + CCNT_W'(1);
                end
            end
            S_DONE:     state_n = rxs ? S_IDLE : S_BRK_WAIT;
            S_BRK_WAIT: if (rxs) state_n = S_IDLE;
            default:    state_n = S_IDLE;
        endcase
    end

    assign bus.RTS      = rts_q;
    assign bus.Rx_Data  = rx_data_q;
    assign bus.Data_Rdy = rdy_q;
    assign bus.Rx_Error = rx_err_q;
    assign bus.Rx_Busy  = (state != S_IDLE);
endmodule
